// File: rtl/pixmem_sched_pkg.sv
// Shared types and frame defaults for the pixel-memory write scheduler.
package pixmem_sched_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sched_state_t;

    localparam int COORD_W_DEF = 9;
    localparam int X_MAX_DEF   = 479;
    localparam int Y_MAX_DEF   = 479;
    localparam int RADIUS_DEF  = 480;
    localparam int CNT_W_DEF   = 32;

    // Width that holds x*x + y*y without overflow.
    function automatic int sq_width(input int coord_w);
        return 2 * coord_w + 2;
    endfunction

endpackage

// File: rtl/circle_test_pipe.sv
// Two-stage quarter-circle membership test: capture, then squares + compare.
// The valid bit travels alongside the data; flush kills everything in flight.
module circle_test_pipe
    import pixmem_sched_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int RADIUS  = RADIUS_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_inside
);

    localparam int SQ_W = sq_width(COORD_W);
    localparam logic [SQ_W-1:0] R_SQ = SQ_W'(RADIUS * RADIUS);

    logic               s1_valid;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;
    logic [SQ_W-1:0]    sum_sq;

    // Sum of squares from the captured sample, unsigned at full width.
    always_comb begin
        sum_sq = SQ_W'(s1_x) * SQ_W'(s1_x) + SQ_W'(s1_y) * SQ_W'(s1_y);
    end

    // Stage 1: capture the accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= in_valid & ~flush;
            s1_x     <= in_x;
            s1_y     <= in_y;
        end
    end

    // Stage 2: register the inside decision; the boundary counts as inside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_inside <= 1'b0;
        end else begin
            out_valid  <= s1_valid & ~flush;
            out_x      <= s1_x;
            out_y      <= s1_y;
            out_inside <= (sum_sq <= R_SQ);
        end
    end

endmodule

// File: rtl/pixmem_write_scheduler.sv
// Pixel-memory write-port owner: clears the frame, then plots accepted
// samples and keeps the total/inside hit counts for the pi readout.
//
//   state | meaning
//   CLEAR | row-major sweep writing 0 to every pixel, samples refused
//   RUN   | samples accepted, in-range hits plotted and counted
module pixmem_write_scheduler
    import pixmem_sched_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF,
    parameter int RADIUS  = RADIUS_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               clear_done,
    input  logic               smp_valid,
    output logic               smp_ready,
    input  logic [COORD_W-1:0] smp_x,
    input  logic [COORD_W-1:0] smp_y,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic               wr_data,
    output logic [CNT_W-1:0]   total_cnt,
    output logic [CNT_W-1:0]   inside_cnt,
    output logic               cnt_sat
);

    localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(Y_MAX);
    localparam logic [CNT_W-1:0]   CNT_TOP  = '1;
    localparam logic [CNT_W-1:0]   CNT_NEAR = CNT_TOP - 1'b1;

    sched_state_t       state;
    logic [COORD_W-1:0] ptr_x;
    logic [COORD_W-1:0] ptr_y;
    logic               sweep_end;
    logic               in_range;
    logic               flush;
    logic               sweep_step;
    logic               p_valid;
    logic [COORD_W-1:0] p_x;
    logic [COORD_W-1:0] p_y;
    logic               p_inside;

    // Handshake and sweep control decoded from state; the pointer is
    // always (0,0) in RUN, so a clear request can write (0,0) immediately.
    always_comb begin
        clear_busy = (state == CLEAR);
        smp_ready  = (state == RUN);
        in_range   = (smp_x <= X_LIM) && (smp_y <= Y_LIM);
        flush      = smp_ready & clear_req;
        sweep_step = (clear_busy & ~sweep_end) | flush;
    end

    circle_test_pipe #(
        .COORD_W (COORD_W),
        .RADIUS  (RADIUS)
    ) u_circle (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (smp_valid & smp_ready & in_range),
        .in_x       (smp_x),
        .in_y       (smp_y),
        .out_valid  (p_valid),
        .out_x      (p_x),
        .out_y      (p_y),
        .out_inside (p_inside)
    );

    // Sequencer: sweep pointer, registered write port, hit counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            ptr_x      <= '0;
            ptr_y      <= '0;
            sweep_end  <= 1'b0;
            wr_en      <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_data    <= 1'b0;
            clear_done <= 1'b0;
            total_cnt  <= '0;
            inside_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_data    <= 1'b0;
            clear_done <= 1'b0;

            if (sweep_step) begin
                wr_en <= 1'b1;
                wr_x  <= ptr_x;
                wr_y  <= ptr_y;
                if (ptr_x == X_LIM) begin
                    ptr_x <= '0;
                    if (ptr_y == Y_LIM) sweep_end <= 1'b1;
                    else                ptr_y     <= ptr_y + 1'b1;
                end else begin
                    ptr_x <= ptr_x + 1'b1;
                end
            end

            case (state)
                CLEAR: begin
                    if (sweep_end) begin
                        state      <= RUN;
                        clear_done <= 1'b1;
                        sweep_end  <= 1'b0;
                        ptr_x      <= '0;
                        ptr_y      <= '0;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        total_cnt  <= '0;
                        inside_cnt <= '0;
                        cnt_sat    <= 1'b0;
                    end else if (p_valid) begin
                        wr_en   <= 1'b1;
                        wr_x    <= p_x;
                        wr_y    <= p_y;
                        wr_data <= 1'b1;
                        // Freeze both counters together so the ratio survives.
                        if (total_cnt != CNT_TOP) begin
                            total_cnt <= total_cnt + 1'b1;
                            if (p_inside) inside_cnt <= inside_cnt + 1'b1;
                            if (total_cnt == CNT_NEAR) cnt_sat <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_pixmem_write_scheduler.sv
// Directed bench for pixmem_write_scheduler on a 4x4 frame, radius 4,
// 4-bit counters.
module tb_pixmem_write_scheduler;

    localparam int COORD_W = 9;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               reset_n;
    logic               clear_req;
    logic               clear_busy;
    logic               clear_done;
    logic               smp_valid;
    logic               smp_ready;
    logic [COORD_W-1:0] smp_x;
    logic [COORD_W-1:0] smp_y;
    logic               wr_en;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_data;
    logic [CNT_W-1:0]   total_cnt;
    logic [CNT_W-1:0]   inside_cnt;
    logic               cnt_sat;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    pixmem_write_scheduler #(
        .COORD_W (COORD_W),
        .X_MAX   (3),
        .Y_MAX   (3),
        .RADIUS  (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_x      (smp_x),
        .smp_y      (smp_y),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .total_cnt  (total_cnt),
        .inside_cnt (inside_cnt),
        .cnt_sat    (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed write port: {wr_en, wr_data, wr_x, wr_y}.
    function automatic logic [31:0] wport(input logic en, input logic d,
                                          input int x, input int y);
        logic [8:0] xx;
        logic [8:0] yy;
        xx = 9'(x);
        yy = 9'(y);
        return {12'd0, en, d, xx, yy};
    endfunction

    // Checks sweep writes start..15, then the clear_done/RUN cycle.
    // A clear_req pulse is offered at index req_at and must be ignored.
    task automatic sweep_tail(input int start, input int req_at);
        for (int i = start; i < 16; i++) begin
            clear_req = (i == req_at);
            step();
            clear_req = 1'b0;
            chk("sweep_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b0, i % 4, i / 4));
            chk("sweep_flags", {29'd0, clear_busy, smp_ready, clear_done}, 32'b100);
        end
        step();
        chk("sweep_done", {28'd0, clear_busy, smp_ready, clear_done, wr_en}, 32'b0110);
        chk("sweep_cnts", {23'd0, total_cnt, inside_cnt, cnt_sat}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        clear_req = 1'b0;
        smp_valid = 1'b0;
        smp_x     = '0;
        smp_y     = '0;

        #3;
        chk("rst_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), 32'd0);
        chk("rst_flags", {29'd0, clear_busy, smp_ready, clear_done}, 32'b100);
        chk("rst_cnts", {23'd0, total_cnt, inside_cnt, cnt_sat}, 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Post-reset sweep.
        sweep_tail(0, -1);

        // Back-to-back samples (3,0), (3,3), (0,0).
        smp_valid = 1'b1; smp_x = 9'd3; smp_y = 9'd0;
        step();
        smp_x = 9'd3; smp_y = 9'd3;
        step();
        smp_x = 9'd0; smp_y = 9'd0;
        step();
        smp_valid = 1'b0;
        chk("plot0", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b1, 3, 0));
        chk("cnt0", {24'd0, total_cnt, inside_cnt}, {24'd0, 4'd1, 4'd1});
        step();
        chk("plot1", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b1, 3, 3));
        chk("cnt1", {24'd0, total_cnt, inside_cnt}, {24'd0, 4'd2, 4'd1});
        step();
        chk("plot2", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b1, 0, 0));
        chk("cnt2", {24'd0, total_cnt, inside_cnt}, {24'd0, 4'd3, 4'd2});
        step();
        chk("plot_idle", {31'd0, wr_en}, 32'd0);

        // Out-of-range samples (4,0) and (0,9).
        smp_valid = 1'b1; smp_x = 9'd4; smp_y = 9'd0;
        step();
        chk("oor_ready0", {31'd0, smp_ready}, 32'd1);
        smp_x = 9'd0; smp_y = 9'd9;
        step();
        smp_valid = 1'b0;
        chk("oor_ready1", {31'd0, smp_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("oor_nowr", {31'd0, wr_en}, 32'd0);
        end
        chk("oor_cnts", {24'd0, total_cnt, inside_cnt}, {24'd0, 4'd3, 4'd2});

        // Accept (1,1), then clear_req on the next cycle: (1,1) is dropped.
        smp_valid = 1'b1; smp_x = 9'd1; smp_y = 9'd1;
        step();
        smp_valid = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_first_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b0, 0, 0));
        chk("clr_busy", {30'd0, clear_busy, smp_ready}, 32'b10);
        chk("clr_cnts", {23'd0, total_cnt, inside_cnt, cnt_sat}, 32'd0);
        sweep_tail(1, 5);

        // Saturation: 17 samples at (0,0); each written, counts stop at 15.
        for (int j = 0; j < 19; j++) begin
            int exp_tot;
            smp_valid = (j < 17);
            smp_x = 9'd0; smp_y = 9'd0;
            step();
            exp_tot = (j >= 2) ? ((j - 1 < 15) ? j - 1 : 15) : 0;
            if (j >= 2)
                chk("sat_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b1, 0, 0));
            chk("sat_cnts", {23'd0, total_cnt, inside_cnt, cnt_sat},
                {23'd0, 4'(exp_tot), 4'(exp_tot), (exp_tot == 15)});
        end
        smp_valid = 1'b0;
        step();
        chk("sat_hold", {23'd0, total_cnt, inside_cnt, cnt_sat}, {23'd0, 4'd15, 4'd15, 1'b1});

        // Reset in the middle of a sweep, right when (2,1) is on the port.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("mid_first_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b0, 0, 0));
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("mid_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), wport(1'b1, 1'b0, i % 4, i / 4));
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr", wport(wr_en, wr_data, int'(wr_x), int'(wr_y)), 32'd0);
        chk("mid_rst_flags", {29'd0, clear_busy, smp_ready, clear_done}, 32'b100);
        chk("mid_rst_cnts", {23'd0, total_cnt, inside_cnt, cnt_sat}, 32'd0);
        step();
        reset_n = 1'b1;
        sweep_tail(0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
